tree_feature_loader: RTL and testbench



---
 rtl/tree_pkg.sv | 18 +
 rtl/tree_feature_loader_if.sv | 30 +++
 rtl/tree_feature_loader.sv | 117 +++++++++++
 tb/tb_tree_feature_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_pkg.sv
// Shared constants and types for the decision-tree feature path: the loader
// that builds the 51-bit feature bus and the tree/vote blocks that consume it.
package tree_pkg;

  localparam int FEAT_W = 51;
  localparam int BEAT_W = 8;
  localparam int BEATS  = (FEAT_W + BEAT_W - 1) / BEAT_W;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } loader_state_e;

  typedef logic [FEAT_W-1:0] feat_vec_t;

endpackage

// File: rtl/tree_feature_loader_if.sv
// Bus bundle between a byte-serial feature source, the loader and the tree
// bank. The slave view belongs to the loader; the master view belongs to
// whatever feeds beats in and consumes the assembled vector.
interface tree_feature_loader_if #(
  parameter int FEAT_W = tree_pkg::FEAT_W,
  parameter int BEAT_W = tree_pkg::BEAT_W,
  parameter int CNT_W  = tree_pkg::CNT_W
);

  logic              s_valid;
  logic              s_ready;
  logic [BEAT_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [FEAT_W-1:0] m_features;
  logic              err_len;
  logic [CNT_W-1:0]  frame_count;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_features, err_len, frame_count
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_features, err_len, frame_count
  );

endinterface

// File: rtl/tree_feature_loader.sv
// Assembles a byte-serial feature stream into one 51-bit vector per frame,
// holds it for the tree bank until consumed, flags malformed frames and
// counts delivered vectors.
module tree_feature_loader
  import tree_pkg::*;
#(
  parameter int FEAT_W = tree_pkg::FEAT_W,
  parameter int BEAT_W = tree_pkg::BEAT_W,
  parameter int CNT_W  = tree_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  tree_feature_loader_if.slave  bus
);

  localparam int BEATS_L = (FEAT_W + BEAT_W - 1) / BEAT_W;
  localparam int IDX_W   = (BEATS_L > 1) ? $clog2(BEATS_L) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS_L - 1);

  loader_state_e     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FEAT_W-1:0] feat_q, feat_d;
  logic [CNT_W-1:0]  frame_count_q, cnt_d;
  logic              err_q, err_d;

  logic s_ready_w;
  logic beat_fire;
  logic vec_take;

  // s_ready comes straight from the state register, gated low during reset
  assign s_ready_w = ~rst & (state_q != HOLD);
  assign beat_fire = bus.s_valid & s_ready_w;
  assign vec_take  = (state_q == HOLD) & bus.m_ready;

  // Next-state, beat index, error pulse and counter decode; s_last and
  // m_ready are only looked at under their qualifying valid
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    cnt_d   = frame_count_q;
    unique case (state_q)
      FILL: begin
        if (beat_fire) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (bus.s_last) begin
              state_d = HOLD;
            end else begin
              state_d = DRAIN;
              err_d   = 1'b1;
            end
          end else if (bus.s_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (beat_fire && bus.s_last) begin
          state_d = FILL;
          idx_d   = '0;
        end
      end
      HOLD: begin
        if (vec_take) begin
          state_d = FILL;
          idx_d   = '0;
          cnt_d   = frame_count_q + 1'b1;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  // Beat write-enable decode: beat k lands in bits [8k+7:8k]; the final
  // beat only covers the bits that exist above the last full byte
  always_comb begin
    feat_d = feat_q;
    if (beat_fire && (state_q == FILL)) begin
      for (int b = 0; b < FEAT_W; b++) begin
        if ((b / BEAT_W) == int'(idx_q)) begin
          feat_d[b] = bus.s_data[b % BEAT_W];
        end
      end
    end
  end

  // State, index, vector, error pulse and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      idx_q         <= '0;
      feat_q        <= '0;
      err_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      feat_q        <= feat_d;
      err_q         <= err_d;
      frame_count_q <= cnt_d;
    end
  end

  assign bus.s_ready     = s_ready_w;
  assign bus.m_valid     = (state_q == HOLD);
  assign bus.m_features  = feat_q;
  assign bus.err_len     = err_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_tree_feature_loader.sv
// Directed bench for tree_feature_loader: well-formed, backpressured, short,
// long, back-to-back and reset-interrupted frames plus counter wrap.
module tb_tree_feature_loader;
  import tree_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   fails;
  int   cyc;

  tree_feature_loader_if bus ();

  tree_feature_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  // Drive one beat, waiting (bounded) for s_ready; returns 1 ns after the
  // accepting edge with the beat inputs released.
  task automatic beat(input logic [7:0] d, input logic l);
    int n;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    n = 0;
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      checks++;
      fails++;
      $display("FAIL beat_accept: s_ready=%0b required=1 after %0d cycles", bus.s_ready, n);
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_data  = 'x;
    bus.s_last  = 'x;
  endtask

  task automatic send_frame(input logic [55:0] bytes);
    for (int k = 0; k < 7; k++) beat(bytes[8*k +: 8], k == 6);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 'x;
    bus.s_last  = 'x;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready: got %0b required 0", bus.s_ready); end
    checks++;
    if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL rst_m_valid: got %0b required 0", bus.m_valid); end
    checks++;
    if (bus.m_features !== 51'h0) begin fails++; $display("FAIL rst_features: got %h required 0", bus.m_features); end
    checks++;
    if (bus.frame_count !== 16'h0) begin fails++; $display("FAIL rst_count: got %h required 0", bus.frame_count); end
    checks++;
    if (bus.err_len !== 1'b0) begin fails++; $display("FAIL rst_err: got %0b required 0", bus.err_len); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL rst_release_s_ready: got %0b required 1", bus.s_ready); end
  endtask

  task automatic test_well_formed();
    bus.m_ready = 1'b1;
    send_frame(56'hFD_20_10_08_04_02_01);
    checks++;
    if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL wf_m_valid: got %0b required 1", bus.m_valid); end
    checks++;
    if (bus.m_features !== 51'h5_2010_0804_0201) begin fails++; $display("FAIL wf_features: got %h required %h", bus.m_features, 51'h5_2010_0804_0201); end
    checks++;
    if (bus.err_len !== 1'b0) begin fails++; $display("FAIL wf_err: got %0b required 0", bus.err_len); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL wf_m_valid_drop: got %0b required 0", bus.m_valid); end
    checks++;
    if (bus.frame_count !== 16'd1) begin fails++; $display("FAIL wf_count: got %0d required 1", bus.frame_count); end
  endtask

  task automatic test_backpressure();
    int bad;
    bus.m_ready = 1'b0;
    send_frame(56'hFD_20_10_08_04_02_01);
    bad = 0;
    // offer junk beats while held; none may be taken
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hEE;
    bus.s_last  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_features !== 51'h5_2010_0804_0201 || bus.s_ready !== 1'b0) begin
        fails++;
        bad++;
        if (bad < 4) $display("FAIL bp_hold c=%0d: m_valid=%0b feat=%h s_ready=%0b required 1/%h/0",
                              c, bus.m_valid, bus.m_features, bus.s_ready, 51'h5_2010_0804_0201);
      end
    end
    bus.s_valid = 1'b0;
    bus.s_data  = 'x;
    bus.s_last  = 'x;
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL bp_release_m_valid: got %0b required 0", bus.m_valid); end
    checks++;
    if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL bp_release_s_ready: got %0b required 1", bus.s_ready); end
    checks++;
    if (bus.frame_count !== 16'd2) begin fails++; $display("FAIL bp_count: got %0d required 2", bus.frame_count); end
  endtask

  task automatic test_short_frame();
    bus.m_ready = 1'b1;
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b0);
    beat(8'hCC, 1'b1);
    checks++;
    if (bus.err_len !== 1'b1) begin fails++; $display("FAIL short_err: got %0b required 1", bus.err_len); end
    checks++;
    if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL short_m_valid: got %0b required 0", bus.m_valid); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.err_len !== 1'b0) begin fails++; $display("FAIL short_err_pulse: got %0b required 0", bus.err_len); end
    checks++;
    if (bus.frame_count !== 16'd2) begin fails++; $display("FAIL short_count: got %0d required 2", bus.frame_count); end
    send_frame(56'hFF_66_55_44_33_22_11);
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_features !== 51'h7_6655_4433_2211) begin
      fails++;
      $display("FAIL short_next_frame: m_valid=%0b feat=%h required 1/%h", bus.m_valid, bus.m_features, 51'h7_6655_4433_2211);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.frame_count !== 16'd3) begin fails++; $display("FAIL short_next_count: got %0d required 3", bus.frame_count); end
  endtask

  task automatic test_long_frame();
    bus.m_ready = 1'b1;
    for (int k = 0; k < 6; k++) beat(8'h40 + 8'(k), 1'b0);
    checks++;
    if (bus.err_len !== 1'b0) begin fails++; $display("FAIL long_err_early: got %0b required 0", bus.err_len); end
    beat(8'h47, 1'b0);
    checks++;
    if (bus.err_len !== 1'b1) begin fails++; $display("FAIL long_err: got %0b required 1", bus.err_len); end
    beat(8'h48, 1'b0);
    checks++;
    if (bus.err_len !== 1'b0 || bus.m_valid !== 1'b0) begin
      fails++;
      $display("FAIL long_beat8: err=%0b m_valid=%0b required 0/0", bus.err_len, bus.m_valid);
    end
    beat(8'h49, 1'b1);
    checks++;
    if (bus.err_len !== 1'b0 || bus.m_valid !== 1'b0) begin
      fails++;
      $display("FAIL long_beat9: err=%0b m_valid=%0b required 0/0", bus.err_len, bus.m_valid);
    end
    send_frame(56'h56_34_12_F0_DE_BC_9A);
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_features !== 51'h6_3412_F0DE_BC9A) begin
      fails++;
      $display("FAIL long_next_frame: m_valid=%0b feat=%h required 1/%h", bus.m_valid, bus.m_features, 51'h6_3412_F0DE_BC9A);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.frame_count !== 16'd4) begin fails++; $display("FAIL long_count: got %0d required 4", bus.frame_count); end
  endtask

  task automatic test_back_to_back();
    int t_a;
    int t_b;
    bus.m_ready = 1'b1;
    send_frame(56'h01_02_03_04_05_06_07);
    t_a = cyc;
    send_frame(56'h02_F1_E2_D3_C4_B5_A6);
    t_b = cyc;
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_features !== 51'h2_F1E2_D3C4_B5A6) begin
      fails++;
      $display("FAIL b2b_frame2: m_valid=%0b feat=%h required 1/%h", bus.m_valid, bus.m_features, 51'h2_F1E2_D3C4_B5A6);
    end
    checks++;
    if (t_b - t_a !== 8) begin fails++; $display("FAIL b2b_period: got %0d cycles required 8", t_b - t_a); end
    checks++;
    if (bus.frame_count !== 16'd5) begin fails++; $display("FAIL b2b_count_mid: got %0d required 5", bus.frame_count); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.frame_count !== 16'd6) begin fails++; $display("FAIL b2b_count: got %0d required 6", bus.frame_count); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_count_q;
    @(negedge clk);
    checks++;
    if (bus.frame_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h required ffff", bus.frame_count); end
    bus.m_ready = 1'b1;
    send_frame(56'h00_00_00_00_00_00_5A);
    @(posedge clk);
    #1;
    checks++;
    if (bus.frame_count !== 16'h0000) begin fails++; $display("FAIL wrap_count: got %h required 0000", bus.frame_count); end
  endtask

  task automatic test_reset_mid();
    bus.m_ready = 1'b1;
    send_frame(56'h03_AB_CD_EF_01_23_45);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) beat(8'h99, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_features !== 51'h0 || bus.frame_count !== 16'h0 || bus.err_len !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_fill: m_valid=%0b feat=%h cnt=%h err=%0b required 0/0/0/0",
               bus.m_valid, bus.m_features, bus.frame_count, bus.err_len);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.err_len !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_fill_release: s_ready=%0b err=%0b required 1/0", bus.s_ready, bus.err_len);
    end
    bus.m_ready = 1'b0;
    send_frame(56'h01_11_22_33_44_55_66);
    checks++;
    if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL rstmid_hold_entry: got %0b required 1", bus.m_valid); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_features !== 51'h0 || bus.frame_count !== 16'h0 || bus.err_len !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_hold: m_valid=%0b feat=%h cnt=%h err=%0b required 0/0/0/0",
               bus.m_valid, bus.m_features, bus.frame_count, bus.err_len);
    end
    checks++;
    if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL rstmid_hold_s_ready: got %0b required 0", bus.s_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_hold_release: s_ready=%0b m_valid=%0b required 1/0", bus.s_ready, bus.m_valid);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    cyc    = 0;
    test_reset();
    test_well_formed();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
